// File: rtl/mem_scan_initiator.sv
// rtl/mem_scan_initiator.sv - block sum/max scanner and write-back initiator for the data memory port
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   start            request pulse, sampled only in IDLE
//   baseAddr         first word to read (latched on accepted start)
//   count            number of words to read, 0 allowed (latched on accepted start)
//   destAddr         address receiving the sum (latched on accepted start)
//   memAddress       memory address (state/index derived, never from memReadData)
//   memWriteData     memory write data, non-zero only in WRITE
//   memWriteEn       memory write enable, high only in WRITE
//   memReadData      combinational read data for memAddress
//   busy             high while reading/writing (cycle before done)
//   done             one-cycle completion pulse
//   error            range error, valid with done, held until next accepted start
//   sum              running/final sum modulo 2^DATA_W
//   maxVal           unsigned maximum of words read
module mem_scan_initiator #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] baseAddr,
  input  logic [ADDR_W-1:0] count,
  input  logic [ADDR_W-1:0] destAddr,
  output logic [ADDR_W-1:0] memAddress,
  output logic [DATA_W-1:0] memWriteData,
  output logic              memWriteEn,
  input  logic [DATA_W-1:0] memReadData,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] sum,
  output logic [DATA_W-1:0] maxVal
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, FINISH} stateT;

  stateT             state, nextState;
  logic [ADDR_W-1:0] baseReg, countReg, destReg, idx;
  logic [ADDR_W:0]   endAddr;
  logic              rangeBad;
  logic              lastRead;

  // One extra bit so base+count cannot wrap and sneak past the depth check.
  assign endAddr  = {1'b0, baseAddr} + {1'b0, count};
  assign rangeBad = (endAddr > (ADDR_W+1)'(MEM_DEPTH)) ||
                    ({1'b0, destAddr} >= (ADDR_W+1)'(MEM_DEPTH));
  // READ is only entered with countReg >= 1, so the subtraction never wraps here.
  assign lastRead = (idx == countReg - ADDR_W'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState    = state;
    memAddress   = '0;
    memWriteData = '0;
    memWriteEn   = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (rangeBad)        nextState = FINISH;
          else if (count == '0) nextState = WRITE;
          else                 nextState = READ;
        end
      end
      READ: begin
        busy       = 1'b1;
        memAddress = baseReg + idx;
        if (lastRead) nextState = WRITE;
      end
      WRITE: begin
        busy         = 1'b1;
        memAddress   = destReg;
        memWriteData = sum;
        memWriteEn   = 1'b1;
        nextState    = FINISH;
      end
      FINISH: begin
        done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baseReg  <= '0;
      countReg <= '0;
      destReg  <= '0;
      idx      <= '0;
      sum      <= '0;
      maxVal   <= '0;
      error    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            baseReg  <= baseAddr;
            countReg <= count;
            destReg  <= destAddr;
            idx      <= '0;
            sum      <= '0;
            maxVal   <= '0;
            error    <= rangeBad;
          end
        end
        READ: begin
          sum <= sum + memReadData;
          if (memReadData > maxVal) maxVal <= memReadData;
          idx <= idx + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_scan_initiator.sv
// tb/tb_mem_scan_initiator.sv - table-driven bench for mem_scan_initiator
module tb_mem_scan_initiator;

  logic        clk;
  logic        rst;
  logic        start;
  logic [9:0]  baseAddr, count, destAddr;
  logic [9:0]  memAddress;
  logic [15:0] memWriteData;
  logic        memWriteEn;
  logic [15:0] memReadData;
  logic        busy, done, error;
  logic [15:0] sum, maxVal;

  mem_scan_initiator #(.ADDR_W(10), .DATA_W(16), .MEM_DEPTH(1000)) dut (
    .clk(clk), .rst(rst), .start(start),
    .baseAddr(baseAddr), .count(count), .destAddr(destAddr),
    .memAddress(memAddress), .memWriteData(memWriteData), .memWriteEn(memWriteEn),
    .memReadData(memReadData),
    .busy(busy), .done(done), .error(error), .sum(sum), .maxVal(maxVal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: preload port for the bench, write port for the DUT.
  logic [15:0] mem [0:1023];
  logic        preEn = 1'b0;
  logic [9:0]  preAddr = '0;
  logic [15:0] preData = '0;
  int          wrCount = 0;
  int          rdCount = 0;
  logic [9:0]  lastWrAddr = '0;

  assign memReadData = mem[memAddress];

  always @(posedge clk) begin
    if (preEn) mem[preAddr] <= preData;
    else if (memWriteEn) begin
      mem[memAddress] <= memWriteData;
      wrCount         <= wrCount + 1;
      lastWrAddr      <= memAddress;
    end
    if (busy && !memWriteEn) rdCount <= rdCount + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [15:0] d);
    preEn = 1'b1; preAddr = a; preData = d;
    @(posedge clk); #1;
    preEn = 1'b0;
  endtask

  // Returns number of edges after the accepting edge at which done is seen, -1 on timeout.
  task automatic waitDone(output int lat);
    lat = -1;
    for (int k = 0; k < 200; k++) begin
      if (done) begin lat = k; break; end
      @(posedge clk); #1;
    end
  endtask

  // Drives start for one edge (the accepting edge), returns #1 after it.
  task automatic pulseStart(input logic [9:0] b, input logic [9:0] c, input logic [9:0] d);
    baseAddr = b; count = c; destAddr = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  typedef struct {
    logic [9:0]  base;
    logic [9:0]  cnt;
    logic [9:0]  dest;
    logic [15:0] expSum;
    logic [15:0] expMax;
    logic        expErr;
    int          expLat;
    int          expReads;
    int          expWrites;
  } vecT;

  vecT vecs[6];

  initial begin
    int lat, wr0, rd0;
    logic [15:0] saved;

    vecs[0] = '{10'd500, 10'd10, 10'd600, 16'd55,     16'd10,     1'b0, 11, 10, 1};
    vecs[1] = '{10'd0,   10'd2,  10'd2,   16'h0002,   16'hFFFF,   1'b0, 3,  2,  1};
    vecs[2] = '{10'd300, 10'd0,  10'd700, 16'd0,      16'd0,      1'b0, 1,  0,  1};
    vecs[3] = '{10'd995, 10'd6,  10'd10,  16'd0,      16'd0,      1'b1, 0,  0,  0};
    vecs[4] = '{10'd0,   10'd1,  10'd1000 - 10'd0, 16'd0, 16'd0,  1'b1, 0,  0,  0};
    vecs[5] = '{10'd995, 10'd5,  10'd999, 16'd15,     16'd5,      1'b0, 6,  5,  1};

    rst = 1'b1; start = 1'b0; baseAddr = '0; count = '0; destAddr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_error", error, 0);
    chk("reset_sum", sum, 0);
    chk("reset_max", maxVal, 0);
    chk("reset_addr", memAddress, 0);
    chk("reset_wdata", memWriteData, 0);
    chk("reset_we", memWriteEn, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) preload(10'(500 + i), 16'(i + 1));
    preload(10'd0, 16'hFFFF);
    preload(10'd1, 16'h0003);
    preload(10'd700, 16'h1234);
    for (int i = 0; i < 5; i++) preload(10'(995 + i), 16'(i + 1));

    for (int i = 0; i < 6; i++) begin
      wr0 = wrCount; rd0 = rdCount;
      pulseStart(vecs[i].base, vecs[i].cnt, vecs[i].dest);
      waitDone(lat);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].expLat);
      chk($sformatf("v%0d_sum", i), sum, vecs[i].expSum);
      chk($sformatf("v%0d_max", i), maxVal, vecs[i].expMax);
      chk($sformatf("v%0d_error", i), error, vecs[i].expErr);
      @(posedge clk); #1;
      chk($sformatf("v%0d_idle_busy", i), busy, 0);
      chk($sformatf("v%0d_error_held", i), error, vecs[i].expErr);
      chk($sformatf("v%0d_writes", i), wrCount - wr0, vecs[i].expWrites);
      chk($sformatf("v%0d_reads", i), rdCount - rd0, vecs[i].expReads);
      if (vecs[i].expWrites != 0) begin
        chk($sformatf("v%0d_wr_addr", i), lastWrAddr, vecs[i].dest);
        chk($sformatf("v%0d_mem_dest", i), mem[vecs[i].dest], vecs[i].expSum);
      end
    end

    // Reset during the 4th READ cycle abandons the scan.
    preload(10'd600, 16'hBEEF);
    wr0 = wrCount;
    pulseStart(10'd500, 10'd10, 10'd600);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_mid_sum_before", sum, 16'd6);
    chk("rst_mid_busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_error", error, 0);
    chk("rst_mid_sum", sum, 0);
    chk("rst_mid_max", maxVal, 0);
    chk("rst_mid_addr", memAddress, 0);
    chk("rst_mid_we", memWriteEn, 0);
    begin
      int doneSeen;
      doneSeen = 0;
      for (int k = 0; k < 15; k++) begin
        if (done || busy) doneSeen++;
        @(posedge clk); #1;
      end
      chk("rst_mid_no_activity", doneSeen, 0);
    end
    chk("rst_mid_no_write", wrCount - wr0, 0);
    chk("rst_mid_mem600", mem[600], 16'hBEEF);

    // A start pulse during READ is ignored; original operation completes.
    wr0 = wrCount;
    pulseStart(10'd500, 10'd10, 10'd600);
    @(posedge clk); #1;
    baseAddr = 10'd0; count = 10'd2; destAddr = 10'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone(lat);
    chk("ign_latency", lat + 2, 11);
    chk("ign_sum", sum, 16'd55);
    chk("ign_max", maxVal, 16'd10);
    saved = mem[2];
    repeat (4) begin
      @(posedge clk); #1;
      chk("ign_idle_busy", busy, 0);
    end
    chk("ign_writes", wrCount - wr0, 1);
    chk("ign_wr_addr", lastWrAddr, 10'd600);
    chk("ign_mem600", mem[600], 16'd55);
    chk("ign_mem2", mem[2], saved);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
